operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for every register in the block.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 write  input  1  register-file write enable.
REQ-005 writenum  input  3  register-file write address (R0..R7).
REQ-006 data_in  input  16  register-file write data.
REQ-007 readnum  input  3  register-file read address.
REQ-008 loada  input  1  capture read data into operand register A.
REQ-009 loadb  input  1  capture read data into operand register B.
REQ-010 loadc  input  1  capture c_in into result register C.
REQ-011 loads  input  1  capture status_in into the status register.
REQ-012 asel  input  1  1 forces ain to 16'h0000; 0 passes register A.
REQ-013 c_in  input  16  ALU result to be registered.
REQ-014 status_in  input  3  {Z,N,V} flags from the ALU.
REQ-015 rd_data  output  16  combinational register-file read data.
REQ-016 ain  output  16  ALU A operand, after the asel mux.
REQ-017 b_out  output  16  registered B operand; drives the shifter data input.
REQ-018 c_out  output  16  registered result.
REQ-019 status_out  output  3  registered {Z,N,V}.

Function
REQ-020 The register file SHALL hold eight 16-bit registers, R0..R7, all writable (no hardwired zero).
REQ-021 rd_data SHALL equal R[readnum] combinationally, with zero latency.
REQ-022 On a rising clk edge with write=1, R[writenum] SHALL take data_in; all other registers hold.
REQ-023 Write and read to the same address in the same cycle: rd_data SHALL show the old value until the edge and the new value after it (no bypass).
REQ-024 On a rising edge with loada=1, A SHALL take rd_data as it was before the edge; otherwise A holds.
REQ-025 On a rising edge with loadb=1, B SHALL take rd_data as it was before the edge; otherwise B holds.
REQ-026 loada and loadb asserted together SHALL load the same rd_data into both A and B.
REQ-027 write together with loada/loadb to the same register SHALL load the pre-write value into A/B.
REQ-028 On a rising edge with loadc=1, C SHALL take c_in; otherwise C holds.
REQ-029 On a rising edge with loads=1, the status register SHALL take status_in; otherwise it holds.
REQ-030 ain SHALL be combinational: 16'h0000 when asel=1, A when asel=0.
REQ-031 b_out and c_out SHALL be driven directly from B and C.
REQ-032 status_out SHALL be driven directly from the status register.
REQ-033 Operand path latency SHALL be exactly one cycle: load strobe at edge N gives new b_out/ain from edge N.
REQ-034 Every load/write enable SHALL be independent; any combination in one cycle SHALL act as the union of the individual actions.
REQ-035 X on an enable SHALL not be relied on; the bench drives only 0/1.

Reset
REQ-036 rst_n=0 SHALL immediately (without a clock edge) clear R0..R7, A, B, C and the status register to 0.
REQ-037 During reset: ain=0, b_out=0, c_out=0, status_out=3'b000, and rd_data=0 for every readnum.
REQ-038 Reset asserted mid-operation SHALL override any simultaneous write/load strobe.
REQ-039 Reset deassertion SHALL not by itself change state; the first edge with rst_n=1 SHALL act on its strobes.

Verification
REQ-040 Write/read: write R3=16'hA5A5, then readnum=3 -> rd_data=16'hA5A5, and all other registers read 0.
REQ-041 Read-during-write: R2=16'h0001, then in one cycle write R2=16'h00F0 with readnum=2 and loadb=1 -> after the edge B=16'h0001 and rd_data=16'h00F0.
REQ-042 Dual load: R5=16'h8000, readnum=5, loada=loadb=1 -> ain=16'h8000 and b_out=16'h8000; then asel=1 -> ain=0.
REQ-043 Result/status: c_in=16'h1234, status_in=3'b010, loadc=loads=1 for one edge, then both 0 with new inputs -> c_out=16'h1234 and status_out=3'b010 hold.
REQ-044 Async reset: with all registers nonzero, pulse rst_n low between clock edges -> all outputs 0 before the next edge.
REQ-045 Reset vs strobe: rst_n=0 coincident with write=1 and loada=1 -> all state remains 0.

Source files
------------

// File: rtl/operand_stage_if.sv
// Datapath bundle between the controller/ALU side and the operand stage.
// Every signal is level-sampled on clk; the stage has no valid/ready handshake.
interface operand_stage_if;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [15:0] c_in;
    logic [2:0]  status_in;
    logic [15:0] rd_data;
    logic [15:0] ain;
    logic [15:0] b_out;
    logic [15:0] c_out;
    logic [2:0]  status_out;

    modport master (
        output write, writenum, data_in, readnum,
        output loada, loadb, loadc, loads, asel, c_in, status_in,
        input  rd_data, ain, b_out, c_out, status_out
    );

    modport slave (
        input  write, writenum, data_in, readnum,
        input  loada, loadb, loadc, loads, asel, c_in, status_in,
        output rd_data, ain, b_out, c_out, status_out
    );
endinterface

// File: rtl/operand_stage.sv
// Operand stage: 8x16 register file, A/B operand registers, result register C
// and {Z,N,V} status register, all cleared asynchronously by rst_n.
module operand_stage (
    input  logic            clk,
    input  logic            rst_n,
    operand_stage_if.slave  bus
);
    logic [15:0] regs [8];
    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [15:0] reg_c;
    logic [2:0]  reg_status;

    // No write bypass: a same-cycle read sees the old contents, and A/B
    // capture that old value too.
    assign bus.rd_data = regs[bus.readnum];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.write) begin
            regs[bus.writenum] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a      <= '0;
            reg_b      <= '0;
            reg_c      <= '0;
            reg_status <= '0;
        end else begin
            if (bus.loada) reg_a      <= bus.rd_data;
            if (bus.loadb) reg_b      <= bus.rd_data;
            if (bus.loadc) reg_c      <= bus.c_in;
            if (bus.loads) reg_status <= bus.status_in;
        end
    end

    assign bus.ain        = bus.asel ? 16'h0000 : reg_a;
    assign bus.b_out      = reg_b;
    assign bus.c_out      = reg_c;
    assign bus.status_out = reg_status;
endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage with hand-computed expectations.
module tb_operand_stage;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    operand_stage_if bus();

    operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.write     = 1'b0;
        bus.writenum  = 3'd0;
        bus.data_in   = 16'h0000;
        bus.loada     = 1'b0;
        bus.loadb     = 1'b0;
        bus.loadc     = 1'b0;
        bus.loads     = 1'b0;
        bus.asel      = 1'b0;
        bus.c_in      = 16'h0000;
        bus.status_in = 3'b000;
    endtask

    task automatic wr(input logic [2:0] num, input logic [15:0] val);
        bus.write    = 1'b1;
        bus.writenum = num;
        bus.data_in  = val;
        tick();
        bus.write    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ain"}, bus.ain, 16'h0000);
        check({tag, "_b"}, bus.b_out, 16'h0000);
        check({tag, "_c"}, bus.c_out, 16'h0000);
        check({tag, "_st"}, {13'b0, bus.status_out}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            bus.readnum = 3'(i);
            #0;
            check($sformatf("%s_rd%0d", tag, i), bus.rd_data, 16'h0000);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        bus.readnum = 3'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // write/read R3
        wr(3'd3, 16'hA5A5);
        for (int i = 0; i < 8; i++) begin
            bus.readnum = 3'(i);
            #1;
            check($sformatf("wr_r3_rd%0d", i), bus.rd_data, (i == 3) ? 16'hA5A5 : 16'h0000);
        end

        // read during write, B captures old value
        wr(3'd2, 16'h0001);
        bus.write    = 1'b1;
        bus.writenum = 3'd2;
        bus.data_in  = 16'h00F0;
        bus.readnum  = 3'd2;
        bus.loadb    = 1'b1;
        #1;
        check("rdw_pre_edge", bus.rd_data, 16'h0001);
        tick();
        idle();
        #1;
        check("rdw_b_old", bus.b_out, 16'h0001);
        check("rdw_rd_new", bus.rd_data, 16'h00F0);

        // dual load and asel
        wr(3'd5, 16'h8000);
        bus.readnum = 3'd5;
        bus.loada   = 1'b1;
        bus.loadb   = 1'b1;
        tick();
        idle();
        #1;
        check("dual_ain", bus.ain, 16'h8000);
        check("dual_b", bus.b_out, 16'h8000);
        bus.asel = 1'b1;
        #1;
        check("asel_zero", bus.ain, 16'h0000);
        bus.asel = 1'b0;
        #1;
        check("asel_pass", bus.ain, 16'h8000);

        // write + loada same register: A takes pre-write value
        bus.write    = 1'b1;
        bus.writenum = 3'd5;
        bus.data_in  = 16'h1111;
        bus.readnum  = 3'd5;
        bus.loada    = 1'b1;
        tick();
        idle();
        #1;
        check("wr_loada_a", bus.ain, 16'h8000);
        check("wr_loada_rd", bus.rd_data, 16'h1111);
        check("hold_b", bus.b_out, 16'h8000);

        // result and status hold
        bus.c_in      = 16'h1234;
        bus.status_in = 3'b010;
        bus.loadc     = 1'b1;
        bus.loads     = 1'b1;
        tick();
        bus.loadc     = 1'b0;
        bus.loads     = 1'b0;
        bus.c_in      = 16'hFFFF;
        bus.status_in = 3'b101;
        tick();
        check("hold_c", bus.c_out, 16'h1234);
        check("hold_st", {13'b0, bus.status_out}, 16'h0002);
        bus.loads = 1'b1;
        tick();
        idle();
        check("load_st2", {13'b0, bus.status_out}, 16'h0005);
        check("c_still", bus.c_out, 16'h1234);

        // every register writable, including R0
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 16'h1000 + 16'(i) * 16'h0111);
        end
        for (int i = 0; i < 8; i++) begin
            bus.readnum = 3'(i);
            #1;
            check($sformatf("all_rd%0d", i), bus.rd_data, 16'h1000 + 16'(i) * 16'h0111);
        end
        bus.readnum = 3'd7;
        bus.loadb   = 1'b1;
        bus.loadc   = 1'b1;
        bus.c_in    = 16'hBEEF;
        tick();
        idle();
        check("b_r7", bus.b_out, 16'h1777);
        check("c_beef", bus.c_out, 16'hBEEF);

        // async reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");

        // reset overrides simultaneous strobes
        bus.write    = 1'b1;
        bus.writenum = 3'd1;
        bus.data_in  = 16'hFFFF;
        bus.readnum  = 3'd1;
        bus.loada    = 1'b1;
        bus.loadb    = 1'b1;
        bus.loadc    = 1'b1;
        bus.loads    = 1'b1;
        bus.c_in     = 16'hFFFF;
        bus.status_in = 3'b111;
        tick();
        check_all_zero("rst_vs_strobe");

        // first edge after release acts on strobes
        idle();
        rst_n = 1'b1;
        bus.write    = 1'b1;
        bus.writenum = 3'd1;
        bus.data_in  = 16'hCAFE;
        bus.readnum  = 3'd1;
        #1;
        check("release_no_change", bus.rd_data, 16'h0000);
        tick();
        idle();
        bus.readnum = 3'd1;
        #1;
        check("release_first_edge", bus.rd_data, 16'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
